hub75_row_monitor: RTL

- Synthesisable, parametrised HUB75 panel-side receiver model used as a checker in display testbenches and on-chip loopback.
- Oversamples the panel interface (bclk, rgb lanes, addr, le, oe) with the system clock.
- Reconstructs each shifted row per chain and reports it on LE, measures OE on-time per enable window, and flags protocol violations in sticky error bits.

---
 rtl/hub75_row_monitor.sv | 249 ++++++++++++++++++++++++
 1 files changed

// File: rtl/hub75_row_monitor.sv
// -----------------------------------------------------------------------------
// hub75_row_monitor
//
// Panel-side HUB75 receiver model. It oversamples the panel interface with
// the system clock, rebuilds each shifted row per RGB chain, reports the row
// when LE rises, measures how long OE was active per enable window, and keeps
// sticky flags for protocol violations.
//
// Optional build macro:
//   HUB75_ROW_MONITOR_DISPLAY_EN - simulation-only $display of every latched
//   row and of every error flag's 0->1 transition. Undefined by default.
//
// Ports:
//   clk                 system sample clock
//   n_reset             asynchronous active-low reset
//   bclk                panel shift clock (asynchronous to clk)
//   rgb_in              lane data, bit 3*ch+0 = R, +1 = G, +2 = B
//   addr_in             row address
//   le_in               latch enable, active high
//   oe_n_in             output enable, active low
//   err_clr             synchronous clear of the sticky error flags
//   row_valid           one-cycle pulse when a row is latched
//   row_addr            address sampled at latch
//   row_data            latched row, slice k = bits [k*NUM_COLS +: NUM_COLS]
//   row_bit_count       bclk rises seen since previous latch (saturating)
//   on_valid            one-cycle pulse when an OE window ends
//   on_addr             address captured at the start of the window
//   on_cycles           clk cycles OE was active (saturating)
//   err_bit_count       sticky: latch with row_bit_count != NUM_COLS
//   err_le_during_oe    sticky: LE rose while OE was active
//   err_addr_during_oe  sticky: address changed while OE was active
// -----------------------------------------------------------------------------
module hub75_row_monitor #(
  parameter int NUM_COLS    = 64,
  parameter int NUM_CHAINS  = 2,
  parameter int ADDR_W      = 4,
  parameter int SYNC_STAGES = 2,
  parameter int ON_W        = 16
) (
  input  logic                               clk,
  input  logic                               n_reset,
  input  logic                               bclk,
  input  logic [3*NUM_CHAINS-1:0]            rgb_in,
  input  logic [ADDR_W-1:0]                  addr_in,
  input  logic                               le_in,
  input  logic                               oe_n_in,
  input  logic                               err_clr,
  output logic                               row_valid,
  output logic [ADDR_W-1:0]                  row_addr,
  output logic [3*NUM_CHAINS*NUM_COLS-1:0]   row_data,
  output logic [$clog2(NUM_COLS+1):0]        row_bit_count,
  output logic                               on_valid,
  output logic [ADDR_W-1:0]                  on_addr,
  output logic [ON_W-1:0]                    on_cycles,
  output logic                               err_bit_count,
  output logic                               err_le_during_oe,
  output logic                               err_addr_during_oe
);

  localparam int LANES = 3 * NUM_CHAINS;
  localparam int CNT_W = $clog2(NUM_COLS + 1) + 1;
  localparam int RW    = LANES * NUM_COLS;
  localparam int SW    = 3 + LANES + ADDR_W;

  // Bundle positions inside the synchroniser word.
  localparam int P_RGB  = ADDR_W;
  localparam int P_OE_N = ADDR_W + LANES;
  localparam int P_LE   = ADDR_W + LANES + 1;
  localparam int P_BCLK = ADDR_W + LANES + 2;

  function automatic logic [CNT_W-1:0] sat_inc_bits(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [ON_W-1:0] sat_inc_on(input logic [ON_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic sticky_next(input logic cur, input logic set, input logic clr);
    // A set event in the same cycle as a clear keeps the flag set.
    return set | (cur & ~clr);
  endfunction

  // ---------------------------------------------------------------------------
  // Synchroniser: every panel input travels through the same flops so data
  // stays aligned with its strobe, then one history flop for edge detect.
  // ---------------------------------------------------------------------------
  logic [SW-1:0] raw_word;
  logic [SW-1:0] sync_q [SYNC_STAGES];
  logic [SW-1:0] hist_q;
  logic [SW-1:0] synced;

  assign raw_word = {bclk, le_in, oe_n_in, rgb_in, addr_in};
  assign synced   = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      hist_q <= '0;
    end else begin
      sync_q[0] <= raw_word;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      hist_q <= synced;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage p0: registered edge strobes with their aligned data.
  // ---------------------------------------------------------------------------
  logic              bclk_rise_p0;
  logic              le_rise_p0;
  logic              oe_fall_p0;
  logic              oe_rise_p0;
  logic              oe_act_p0;
  logic [LANES-1:0]  rgb_p0;
  logic [ADDR_W-1:0] addr_p0;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      bclk_rise_p0 <= 1'b0;
      le_rise_p0   <= 1'b0;
      oe_fall_p0   <= 1'b0;
      oe_rise_p0   <= 1'b0;
      oe_act_p0    <= 1'b0;
      rgb_p0       <= '0;
      addr_p0      <= '0;
    end else begin
      bclk_rise_p0 <= synced[P_BCLK] & ~hist_q[P_BCLK];
      le_rise_p0   <= synced[P_LE]   & ~hist_q[P_LE];
      oe_fall_p0   <= ~synced[P_OE_N] & hist_q[P_OE_N];
      oe_rise_p0   <= synced[P_OE_N] & ~hist_q[P_OE_N];
      oe_act_p0    <= ~synced[P_OE_N];
      rgb_p0       <= synced[P_RGB +: LANES];
      addr_p0      <= synced[ADDR_W-1:0];
    end
  end

  // Shift and count are resolved combinationally so that a latch in the same
  // cycle as a shift captures the freshly shifted bit.
  logic [RW-1:0]    shift_q;
  logic [RW-1:0]    shift_nxt;
  logic [CNT_W-1:0] bit_cnt_q;
  logic [CNT_W-1:0] bit_cnt_nxt;

  always_comb begin
    shift_nxt   = shift_q;
    bit_cnt_nxt = bit_cnt_q;
    if (bclk_rise_p0) begin
      for (int k = 0; k < LANES; k++) begin
        shift_nxt[k*NUM_COLS +: NUM_COLS] =
          {shift_q[k*NUM_COLS +: NUM_COLS-1], rgb_p0[k]};
      end
      bit_cnt_nxt = sat_inc_bits(bit_cnt_q);
    end
  end

  // OE window state.
  logic              in_win_q;
  logic [ADDR_W-1:0] win_addr_q;
  logic [ON_W-1:0]   on_cnt_q;

  // Error set events and next sticky values.
  logic set_bit_err;
  logic set_le_err;
  logic set_addr_err;
  logic err_bit_nxt;
  logic err_le_nxt;
  logic err_addr_nxt;

  always_comb begin
    set_bit_err  = le_rise_p0 && (bit_cnt_nxt != CNT_W'(NUM_COLS));
    set_le_err   = le_rise_p0 && oe_act_p0;
    set_addr_err = in_win_q && oe_act_p0 && !oe_fall_p0 && (addr_p0 != win_addr_q);
    err_bit_nxt  = sticky_next(err_bit_count,      set_bit_err,  err_clr);
    err_le_nxt   = sticky_next(err_le_during_oe,   set_le_err,   err_clr);
    err_addr_nxt = sticky_next(err_addr_during_oe, set_addr_err, err_clr);
  end

  // ---------------------------------------------------------------------------
  // Stage p1: row latch, OE window measurement, sticky errors.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      shift_q            <= '0;
      bit_cnt_q          <= '0;
      row_valid          <= 1'b0;
      row_addr           <= '0;
      row_data           <= '0;
      row_bit_count      <= '0;
      in_win_q           <= 1'b0;
      win_addr_q         <= '0;
      on_cnt_q           <= '0;
      on_valid           <= 1'b0;
      on_addr            <= '0;
      on_cycles          <= '0;
      err_bit_count      <= 1'b0;
      err_le_during_oe   <= 1'b0;
      err_addr_during_oe <= 1'b0;
    end else begin
      row_valid <= 1'b0;
      on_valid  <= 1'b0;

      shift_q <= shift_nxt;
      if (le_rise_p0) begin
        row_valid     <= 1'b1;
        row_data      <= shift_nxt;
        row_addr      <= addr_p0;
        row_bit_count <= bit_cnt_nxt;
        bit_cnt_q     <= '0;
      end else begin
        bit_cnt_q <= bit_cnt_nxt;
      end

      // The window flag is cleared by reset, so an interrupted window never
      // reports even though the synchronised OE later returns high.
      if (oe_fall_p0) begin
        in_win_q   <= 1'b1;
        win_addr_q <= addr_p0;
        on_cnt_q   <= ON_W'(1);
      end else if (in_win_q && oe_rise_p0) begin
        in_win_q  <= 1'b0;
        on_valid  <= 1'b1;
        on_addr   <= win_addr_q;
        on_cycles <= on_cnt_q;
      end else if (in_win_q) begin
        on_cnt_q <= sat_inc_on(on_cnt_q);
      end

      err_bit_count      <= err_bit_nxt;
      err_le_during_oe   <= err_le_nxt;
      err_addr_during_oe <= err_addr_nxt;
    end
  end

`ifdef HUB75_ROW_MONITOR_DISPLAY_EN
  always_ff @(posedge clk) begin
    if (row_valid)
      $display("%0t hub75_row_monitor: row addr=%0h bits=%0d data=%h",
               $time, row_addr, row_bit_count, row_data);
    if (n_reset && err_bit_nxt && !err_bit_count)
      $display("%0t hub75_row_monitor: err_bit_count set", $time);
    if (n_reset && err_le_nxt && !err_le_during_oe)
      $display("%0t hub75_row_monitor: err_le_during_oe set", $time);
    if (n_reset && err_addr_nxt && !err_addr_during_oe)
      $display("%0t hub75_row_monitor: err_addr_during_oe set", $time);
  end
`endif

endmodule
